fc_mem_sequencer: RTL
=====================

FC_MEM_SEQUENCER -- requirements
Module: fc_mem_sequencer

Interface
REQ-001 SHALL have parameters: DATA_W, default 16, data word width; ADDR_W, default 16, address width; NUM_LAYERS, default 2, number of FC layers (valid range 1..7); RGN_W = clog2(NUM_LAYERS+1), memory region select width.
REQ-002 SHALL have these ports (name, direction, width, meaning), clock and reset first:
- clk in 1: single clock, rising edge.
- reset_n in 1: synchronous, active-low reset.
- load_req in 1: pulse, requests an external load into region load_rgn.
- load_rgn in RGN_W: target region; 0..NUM_LAYERS-1 = weight layer k, NUM_LAYERS = right-answer region.
- ex_we in 1: external write enable.
- ex_last in 1: qualifies the final external word; meaningful only with ex_we.
- ex_data in DATA_W: external write data.
- ex_addr in ADDR_W: external write address.
- enable in 1: pulse, starts the forward pass.
- eng_we in 1: compute engine write enable.
- eng_data in DATA_W: compute engine write data.
- eng_addr in ADDR_W: compute engine write address.
- layer_done in 1: pulse, current layer computation finished.
- bck_prop_start in 1: pulse, starts back-propagation.
- bck_end in 1: pulse, back-propagation finished.
- mem_we out 1: memory write enable.
- mem_data out DATA_W: memory write data.
- mem_addr out ADDR_W: memory write address.
- mem_rgn out RGN_W: memory region select.
- state out 2: current state.
- busy out 1: high whenever state is not IDLE.
- load_cnt out ADDR_W: number of words written in the current or last load.
- all_end out 1: one-cycle pulse, forward pass complete.
- bck_done out 1: one-cycle pulse, back-propagation complete.
- err out 1: one-cycle pulse, request rejected.

Function
REQ-003 SHALL implement a four-state FSM: IDLE=0, LOAD=1, FWD=2, BCK=3.
REQ-004 In IDLE, requests SHALL be taken in priority order load_req > enable > bck_prop_start; a lower-priority request arriving in the same cycle SHALL be dropped and SHALL pulse err.
REQ-005 On load_req with load_rgn <= NUM_LAYERS: go to LOAD, latch the region onto mem_rgn, clear load_cnt.
REQ-006 On load_req with load_rgn > NUM_LAYERS: stay in IDLE and pulse err.
REQ-007 In LOAD, each ex_we SHALL increment load_cnt. load_cnt SHALL wrap modulo 2^ADDR_W.
REQ-008 In LOAD, ex_we with ex_last SHALL return the FSM to IDLE on the next cycle; that final word SHALL still be written.
REQ-009 On enable: go to FWD with layer index = 0 and mem_rgn = 0.
REQ-010 In FWD, each layer_done SHALL increment the layer index and mem_rgn.
REQ-011 In FWD, the NUM_LAYERS-th layer_done SHALL return the FSM to IDLE, pulse all_end in the same cycle that IDLE is entered, and set an internal fwd_valid flag.
REQ-012 On bck_prop_start with fwd_valid=1: go to BCK with mem_rgn = NUM_LAYERS.
REQ-013 On bck_prop_start with fwd_valid=0: stay in IDLE and pulse err.
REQ-014 In BCK, bck_end SHALL return the FSM to IDLE, pulse bck_done, and clear fwd_valid.
REQ-015 In any non-IDLE state, load_req, enable or bck_prop_start SHALL be ignored and SHALL pulse err.
REQ-016 The memory write port SHALL be registered with 1-cycle latency: mem_we/mem_data/mem_addr take ex_* in LOAD and eng_* in FWD/BCK.
REQ-017 In IDLE, mem_we SHALL be 0; mem_data and mem_addr SHALL hold their previous values.
REQ-018 ex_we outside LOAD and eng_we outside FWD/BCK SHALL be ignored; no err is raised.
REQ-019 layer_done outside FWD and bck_end outside BCK SHALL be ignored.
REQ-020 mem_rgn SHALL hold its last value in IDLE.

Reset
REQ-021 On reset_n=0 at a clock edge, all of the following SHALL be forced:
- state = IDLE, busy = 0, fwd_valid = 0;
- mem_we = 0, mem_data = 0, mem_addr = 0, mem_rgn = 0;
- load_cnt = 0, layer index = 0;
- all_end = bck_done = err = 0.
REQ-022 Reset asserted mid-LOAD, FWD or BCK SHALL abort the operation with no completion pulse; any write registered in that cycle SHALL be suppressed.

Structure
REQ-023 State encodings and region-select width helpers SHALL live in a shared package, fc_pkg.
REQ-024 The registered memory port mux SHALL be one sub-module, fc_wr_port_mux; the FSM, counters and pulses SHALL stay in the top.

Verification
REQ-025 The bench SHALL cover these directed scenarios (NUM_LAYERS=2):
- Load: load_req with rgn=1, then 5 ex_we with the last flagged -> mem_rgn=1, 5 writes each one cycle late, load_cnt=5, IDLE on the next cycle.
- Bad region: load_req with rgn=3 -> err pulse, state stays 0.
- Forward pass: enable, then two layer_done pulses -> mem_rgn sequence 0,1,2, single all_end pulse, eng writes mirrored with 1-cycle latency.
- Back-prop guard: bck_prop_start before any forward pass -> err; after a forward pass -> BCK with mem_rgn=2; bck_end -> bck_done, IDLE.
- Simultaneous requests: load_req and enable in the same cycle -> LOAD entered, err pulse; enable during LOAD -> err, LOAD continues.
- Mid-operation reset: reset_n=0 during FWD after one layer_done -> all outputs 0, no all_end pulse, a following bck_prop_start is rejected with err.

Source files
------------

// File: rtl/fc_pkg.sv
// Shared definitions for the FC memory sequencer: FSM state encoding and the
// helper that sizes the memory region select.
package fc_pkg;

  localparam int unsigned STATE_W = 2;

  // Sequencer states; the encoding is visible on the state output.
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FWD  = 2'd2,
    ST_BCK  = 2'd3
  } fc_state_e;

  // Region select must address NUM_LAYERS weight regions plus the answer region.
  function automatic int unsigned rgn_width(input int unsigned num_layers);
    return $clog2(num_layers + 1);
  endfunction

endpackage

// File: rtl/fc_wr_port_mux.sv
// Registered memory write port. Selects the external loader in LOAD and the
// compute engine in FWD/BCK; in IDLE the write enable drops and data/address hold.
// Ports:
//   clk, reset_n            clock, synchronous active-low reset
//   sel                     current sequencer state
//   ex_we/ex_data/ex_addr   external write source
//   eng_we/eng_data/eng_addr compute engine write source
//   mem_we/mem_data/mem_addr registered memory write port
module fc_wr_port_mux
  import fc_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  fc_state_e         sel,
  input  logic              ex_we,
  input  logic [DATA_W-1:0] ex_data,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic              eng_we,
  input  logic [DATA_W-1:0] eng_data,
  input  logic [ADDR_W-1:0] eng_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_data,
  output logic [ADDR_W-1:0] mem_addr
);

  // Reset wins over any write presented in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mem_we   <= 1'b0;
      mem_data <= '0;
      mem_addr <= '0;
    end else begin
      case (sel)
        ST_LOAD: begin
          mem_we   <= ex_we;
          mem_data <= ex_data;
          mem_addr <= ex_addr;
        end
        ST_FWD, ST_BCK: begin
          mem_we   <= eng_we;
          mem_data <= eng_data;
          mem_addr <= eng_addr;
        end
        default: mem_we <= 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/fc_mem_sequencer.sv
// Sequences memory access for an FC network: external loads into weight or
// answer regions, a layer-by-layer forward pass, and a back-propagation phase.
// Ports:
//   clk, reset_n                       clock, synchronous active-low reset
//   load_req/load_rgn                  external load request and target region
//   ex_we/ex_last/ex_data/ex_addr      external write stream
//   enable                             start forward pass
//   eng_we/eng_data/eng_addr           compute engine write stream
//   layer_done, bck_prop_start, bck_end engine handshakes
//   mem_we/mem_data/mem_addr/mem_rgn   registered memory write port
//   state, busy, load_cnt              status
//   all_end, bck_done, err             one-cycle status pulses
module fc_mem_sequencer
  import fc_pkg::*;
#(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned NUM_LAYERS = 2,
  parameter int unsigned RGN_W      = rgn_width(NUM_LAYERS)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load_req,
  input  logic [RGN_W-1:0]   load_rgn,
  input  logic               ex_we,
  input  logic               ex_last,
  input  logic [DATA_W-1:0]  ex_data,
  input  logic [ADDR_W-1:0]  ex_addr,
  input  logic               enable,
  input  logic               eng_we,
  input  logic [DATA_W-1:0]  eng_data,
  input  logic [ADDR_W-1:0]  eng_addr,
  input  logic               layer_done,
  input  logic               bck_prop_start,
  input  logic               bck_end,
  output logic               mem_we,
  output logic [DATA_W-1:0]  mem_data,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [RGN_W-1:0]   mem_rgn,
  output logic [STATE_W-1:0] state,
  output logic               busy,
  output logic [ADDR_W-1:0]  load_cnt,
  output logic               all_end,
  output logic               bck_done,
  output logic               err
);

  localparam logic [RGN_W-1:0] ANS_RGN    = RGN_W'(NUM_LAYERS);
  localparam logic [RGN_W-1:0] LAST_LAYER = RGN_W'(NUM_LAYERS - 1);

  fc_state_e         state_q, state_d;
  logic [RGN_W-1:0]  layer_q, layer_d;
  logic [RGN_W-1:0]  rgn_d;
  logic [ADDR_W-1:0] cnt_d;
  logic              fwd_valid_q, fwd_valid_d;
  logic              all_end_d, bck_done_d, err_d;

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      layer_q     <= '0;
      mem_rgn     <= '0;
      load_cnt    <= '0;
      fwd_valid_q <= 1'b0;
      busy        <= 1'b0;
      all_end     <= 1'b0;
      bck_done    <= 1'b0;
      err         <= 1'b0;
    end else begin
      state_q     <= state_d;
      layer_q     <= layer_d;
      mem_rgn     <= rgn_d;
      load_cnt    <= cnt_d;
      fwd_valid_q <= fwd_valid_d;
      busy        <= (state_d != ST_IDLE);
      all_end     <= all_end_d;
      bck_done    <= bck_done_d;
      err         <= err_d;
    end
  end

  // Next-state and counter logic; IDLE arbitrates load_req > enable > bck_prop_start.
  always_comb begin
    state_d     = state_q;
    layer_d     = layer_q;
    rgn_d       = mem_rgn;
    cnt_d       = load_cnt;
    fwd_valid_d = fwd_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (load_req) begin
          if (load_rgn <= ANS_RGN) begin
            state_d = ST_LOAD;
            rgn_d   = load_rgn;
            cnt_d   = '0;
          end
        end else if (enable) begin
          state_d = ST_FWD;
          layer_d = '0;
          rgn_d   = '0;
        end else if (bck_prop_start && fwd_valid_q) begin
          state_d = ST_BCK;
          rgn_d   = ANS_RGN;
        end
      end
      ST_LOAD: begin
        if (ex_we) begin
          cnt_d = load_cnt + ADDR_W'(1);
          if (ex_last) state_d = ST_IDLE;
        end
      end
      ST_FWD: begin
        if (layer_done) begin
          layer_d = layer_q + RGN_W'(1);
          rgn_d   = mem_rgn + RGN_W'(1);
          if (layer_q == LAST_LAYER) begin
            state_d     = ST_IDLE;
            fwd_valid_d = 1'b1;
          end
        end
      end
      ST_BCK: begin
        if (bck_end) begin
          state_d     = ST_IDLE;
          fwd_valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Status pulse decode; err flags dropped, invalid or out-of-state requests.
  always_comb begin
    all_end_d  = 1'b0;
    bck_done_d = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load_req)
          err_d = (load_rgn > ANS_RGN) || enable || bck_prop_start;
        else if (enable)
          err_d = bck_prop_start;
        else
          err_d = bck_prop_start && !fwd_valid_q;
      end
      ST_FWD: begin
        all_end_d = layer_done && (layer_q == LAST_LAYER);
        err_d     = load_req || enable || bck_prop_start;
      end
      ST_BCK: begin
        bck_done_d = bck_end;
        err_d      = load_req || enable || bck_prop_start;
      end
      default: err_d = load_req || enable || bck_prop_start;
    endcase
  end

  assign state = state_q;

  fc_wr_port_mux #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_wr_port_mux (
    .clk      (clk),
    .reset_n  (reset_n),
    .sel      (state_q),
    .ex_we    (ex_we),
    .ex_data  (ex_data),
    .ex_addr  (ex_addr),
    .eng_we   (eng_we),
    .eng_data (eng_data),
    .eng_addr (eng_addr),
    .mem_we   (mem_we),
    .mem_data (mem_data),
    .mem_addr (mem_addr)
  );

endmodule
